// File: rtl/demux_rr_sched.sv
// Round-robin scheduler that grants one of 8 demux sink channels and gates a bounded source burst per grant.
// Optional Mask input is compiled in with `define DEMUX_SCHED_MASK_EN.
module demux_rr_sched #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Req,
`ifdef DEMUX_SCHED_MASK_EN
    input  logic [7:0] Mask,
`endif
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic [2:0] Sel,
    output logic       E,
    output logic [7:0] Gnt,
    output logic       Busy
);

    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("demux_rr_sched: BURST_LEN must be in 1..255");
    end
    if ((64'd1 << CNT_W) <= 64'(BURST_LEN)) begin : g_bad_cnt_w
        $error("demux_rr_sched: CNT_W too narrow for BURST_LEN");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       last_q, last_d;
    logic             e_q, e_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] elig;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;
    logic       beat;
    logic       last_beat;

`ifdef DEMUX_SCHED_MASK_EN
    assign elig = Req & ~Mask;
`else
    assign elig = Req;
`endif

    // Search starts one past the last served channel, so that channel ends up at lowest priority.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign beat      = (state_q == BURST) && In_Valid;
    assign last_beat = beat && ((cnt_q + CNT_W'(1)) == CNT_W'(BURST_LEN));

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    sel_d   = winner;
                    e_d     = 1'b1;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last_beat || !elig[sel_q]) begin
                    state_d = GAP;
                    e_d     = 1'b0;
                    last_d  = sel_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                e_d     = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= 3'd7;
            e_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
        end
    end

    assign In_Ready = (state_q == BURST);
    assign Sel      = sel_q;
    assign E        = e_q;
    assign Gnt      = e_q ? (8'b1 << sel_q) : 8'b0;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: per-cycle vector table, a scoreboard for the round-robin grant order,
// and a Mask sequence when DEMUX_SCHED_MASK_EN is defined.
module tb_demux_rr_sched;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] Req;
    logic [7:0] Mask;
    logic       In_Valid;
    logic       In_Ready;
    logic [2:0] Sel;
    logic       E;
    logic [7:0] Gnt;
    logic       Busy;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    demux_rr_sched #(.BURST_LEN(4), .CNT_W(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Req      (Req),
`ifdef DEMUX_SCHED_MASK_EN
        .Mask     (Mask),
`endif
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Sel      (Sel),
        .E        (E),
        .Gnt      (Gnt),
        .Busy     (Busy)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       valid;
        logic [2:0] sel;
        logic       e;
        logic [7:0] gnt;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [7:0] req, input logic valid,
                       input logic [2:0] sel, input logic e, input logic [7:0] gnt,
                       input logic rdy, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.valid = valid;
        v.sel = sel; v.e = e; v.gnt = gnt; v.rdy = rdy; v.busy = busy;
        vecs.push_back(v);
    endtask

    function automatic logic [13:0] pack_exp(input vec_t v);
        return {v.sel, v.e, v.gnt, v.rdy, v.busy};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Req = '0; Mask = '0; In_Valid = 1'b0;

        // Expected outputs after the edge that samples each row's inputs.
        // Reset, then idle with no requests.
        add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        // Single requester ch3: 4 beats, GAP, IDLE, regrant to ch3.
        for (int i = 0; i < 4; i++) add(0, 8'h08, 1, 3, 1, 8'h08, 1, 1);
        add(0, 8'h08, 1, 3, 0, 8'h00, 0, 1);
        add(0, 8'h08, 1, 3, 0, 8'h00, 0, 0);
        add(0, 8'h08, 1, 3, 1, 8'h08, 1, 1);
        // Reset restarts search at ch0 (ch2 beats ch4); reset mid-burst aborts.
        add(1, 8'h08, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h14, 1, 2, 1, 8'h04, 1, 1);
        add(0, 8'h14, 1, 2, 1, 8'h04, 1, 1);
        add(1, 8'h14, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h14, 1, 2, 1, 8'h04, 1, 1);
        // Ch5 drops its request on the 2nd beat: burst ends, next winner above 5 is ch6.
        add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(0, 8'h20, 1, 5, 1, 8'h20, 1, 1);
        add(0, 8'h20, 1, 5, 1, 8'h20, 1, 1);
        add(0, 8'h41, 1, 5, 0, 8'h00, 0, 1);
        add(0, 8'h41, 1, 5, 0, 8'h00, 0, 0);
        add(0, 8'h41, 1, 6, 1, 8'h40, 1, 1);
        // In_Valid low stalls the burst without counting; other requests ignored.
        add(0, 8'h41, 0, 6, 1, 8'h40, 1, 1);
        add(0, 8'h41, 0, 6, 1, 8'h40, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 8'h41, 1, 6, 1, 8'h40, 1, 1);
        add(0, 8'h41, 1, 6, 0, 8'h00, 0, 1);
        add(0, 8'h41, 1, 6, 0, 8'h00, 0, 0);
        add(0, 8'h41, 1, 0, 1, 8'h01, 1, 1);

        foreach (vecs[k]) begin
            Rst = vecs[k].rst; Req = vecs[k].req; In_Valid = vecs[k].valid;
            @(negedge Clk);
            check($sformatf("vec%0d {sel,e,gnt,rdy,busy}", k),
                  32'({Sel, E, Gnt, In_Ready, Busy}), 32'(pack_exp(vecs[k])));
        end

        // All 8 requesting: order 0..7,0,1, 4 beats per grant, 6-cycle period.
        Rst = 1'b1; Req = 8'hFF; In_Valid = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back(3'(i));
        begin
            int rises = 0;
            int cyc = 0;
            int last_rise = -1;
            int beats = 0;
            logic prev_e = 1'b0;
            logic [2:0] exp_sel;
            while (rises < 10 && cyc < 100) begin
                @(negedge Clk);
                if (E && !prev_e) begin
                    exp_sel = exp_q.pop_front();
                    check($sformatf("rr grant %0d sel", rises), 32'(Sel), 32'(exp_sel));
                    check($sformatf("rr grant %0d gnt", rises), 32'(Gnt), 32'(8'b1 << exp_sel));
                    if (last_rise >= 0)
                        check($sformatf("rr grant %0d period", rises), 32'(cyc - last_rise), 32'd6);
                    last_rise = cyc;
                    beats = 0;
                    rises++;
                end
                if (!E && prev_e)
                    check($sformatf("rr burst before grant %0d beats", rises), 32'(beats), 32'd4);
                if (In_Ready && In_Valid) beats++;
                prev_e = E;
                cyc++;
            end
            check("rr scoreboard drained", 32'(exp_q.size()), 32'd0);
        end

`ifdef DEMUX_SCHED_MASK_EN
        // Masked ch0 is skipped; masking active ch7 ends its burst and ch0 wins next.
        Rst = 1'b1; Req = 8'h81; Mask = 8'h01; In_Valid = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("mask grant ch7", 32'({Sel, E}), 32'({3'd7, 1'b1}));
        @(negedge Clk);
        Mask = 8'h80;
        @(negedge Clk);
        check("mask ends burst", 32'({E, Busy}), 32'({1'b0, 1'b1}));
        @(negedge Clk);
        check("mask idle", 32'({E, Busy}), 32'({1'b0, 1'b0}));
        @(negedge Clk);
        check("mask grant ch0", 32'({Sel, E, Gnt}), 32'({3'd0, 1'b1, 8'h01}));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
